// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads 16-bit words from instruction memory over a
// req/ready handshake and hands each one to the IR with a single-cycle strobe.
module instruction_fetch #(
    parameter int unsigned       PC_W     = 8,
    parameter logic [PC_W-1:0]   RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            run,
    input  logic            stall,
    input  logic            redirect_en,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            mem_req,
    output logic [PC_W-1:0] mem_addr,
    input  logic            mem_ready,
    input  logic [15:0]     mem_rdata,
    output logic [15:0]     instruction_out,
    output logic            IR_in_en,
    output logic [PC_W-1:0] pc_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DELIVER = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     instr_q, instr_d;
    logic [PC_W-1:0] pc_out_q, pc_out_d;

    // Outputs decode straight from registered state, so they are glitch-free
    // with respect to the state flops; IR_in_en alone also looks at stall/redirect.
    assign mem_req         = (state_q == FETCH);
    assign mem_addr        = pc_q;
    assign IR_in_en        = (state_q == DELIVER) && !stall && !redirect_en;
    assign instruction_out = instr_q;
    assign pc_out          = pc_out_q;

    always_comb begin
        // NOTE: every _d gets a hold default first so no path leaves it
        // unassigned; that is what keeps this block from inferring latches.
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;

        if (redirect_en) begin
            // Redirect wins over capture, delivery and stall alike.
            pc_d    = redirect_pc;
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (run) state_d = FETCH;
                end
                FETCH: begin
                    if (mem_ready) begin
                        instr_d  = mem_rdata;
                        pc_out_d = pc_q;
                        state_d  = DELIVER;
                    end
                end
                DELIVER: begin
                    if (!stall) begin
                        pc_d    = pc_q + PC_W'(1);
                        state_d = run ? FETCH : IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            instr_q  <= 16'h0000;
            pc_out_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a behavioural memory returns {A0,addr}
// after a programmable number of wait cycles; each task checks one scenario.
module tb_instruction_fetch;

    localparam int unsigned     PC_W     = 8;
    localparam logic [PC_W-1:0] RESET_PC = 8'h10;

    logic            clock = 1'b0;
    logic            reset;
    logic            run;
    logic            stall;
    logic            redirect_en;
    logic [PC_W-1:0] redirect_pc;
    logic            mem_req;
    logic [PC_W-1:0] mem_addr;
    logic            mem_ready;
    logic [15:0]     mem_rdata;
    logic [15:0]     instruction_out;
    logic            IR_in_en;
    logic [PC_W-1:0] pc_out;

    int errors = 0;
    int checks = 0;
    int latency = 0;
    int req_cycles = 0;

    instruction_fetch #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
        .clock           (clock),
        .reset           (reset),
        .run             (run),
        .stall           (stall),
        .redirect_en     (redirect_en),
        .redirect_pc     (redirect_pc),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_ready       (mem_ready),
        .mem_rdata       (mem_rdata),
        .instruction_out (instruction_out),
        .IR_in_en        (IR_in_en),
        .pc_out          (pc_out)
    );

    always #5 clock = ~clock;

    // Memory model: ready after `latency` cycles of a held request.
    always @(posedge clock) begin
        if (reset || !mem_req || mem_ready) req_cycles <= 0;
        else                                req_cycles <= req_cycles + 1;
    end
    assign mem_ready = mem_req && (req_cycles >= latency);
    assign mem_rdata = {8'hA0, mem_addr};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b0; stall = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
        tick();
        tick();
        reset = 1'b0;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        checks++; if (IR_in_en !== 1'b0) begin errors++; $display("FAIL reset_ir_en: got %b want 0", IR_in_en); end
        checks++; if (instruction_out !== 16'h0000) begin errors++; $display("FAIL reset_instr: got %h want 0000", instruction_out); end
        checks++; if (pc_out !== 8'h10) begin errors++; $display("FAIL reset_pc_out: got %h want 10", pc_out); end
        checks++; if (mem_addr !== 8'h10) begin errors++; $display("FAIL reset_pc: got %h want 10", mem_addr); end
        tick();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL idle_no_run: got %b want 0", mem_req); end
    endtask

    task automatic test_sequential();
        logic [7:0] a;
        latency = 0;
        run = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a = 8'h10 + 8'(k);
            tick();
            checks++; if (mem_req !== 1'b1 || mem_addr !== a) begin errors++; $display("FAIL seq_fetch%0d: got req=%b addr=%h want req=1 addr=%h", k, mem_req, mem_addr, a); end
            checks++; if (IR_in_en !== 1'b0) begin errors++; $display("FAIL seq_ir_gap%0d: got %b want 0", k, IR_in_en); end
            tick();
            checks++; if (IR_in_en !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL seq_deliver%0d: got ir=%b req=%b want ir=1 req=0", k, IR_in_en, mem_req); end
            checks++; if (instruction_out !== {8'hA0, a} || pc_out !== a) begin errors++; $display("FAIL seq_data%0d: got instr=%h pc_out=%h want instr=%h pc_out=%h", k, instruction_out, pc_out, {8'hA0, a}, a); end
        end
        run = 1'b0;
        tick();
        checks++; if (mem_req !== 1'b0 || mem_addr !== 8'h13 || IR_in_en !== 1'b0) begin errors++; $display("FAIL run_low_idle: got req=%b addr=%h ir=%b want req=0 addr=13 ir=0", mem_req, mem_addr, IR_in_en); end
        tick();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL run_low_stays: got req=%b want 0", mem_req); end
    endtask

    task automatic test_wait_states();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        latency = 3;
        run = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h10 || IR_in_en !== 1'b0) begin errors++; $display("FAIL wait_hold%0d: got req=%b addr=%h ir=%b want req=1 addr=10 ir=0", c, mem_req, mem_addr, IR_in_en); end
        end
        tick();
        checks++; if (IR_in_en !== 1'b1 || instruction_out !== 16'hA010 || pc_out !== 8'h10) begin errors++; $display("FAIL wait_deliver: got ir=%b instr=%h pc_out=%h want ir=1 instr=A010 pc_out=10", IR_in_en, instruction_out, pc_out); end
        latency = 0;
        tick();
        checks++; if (IR_in_en !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 8'h11) begin errors++; $display("FAIL wait_next: got ir=%b req=%b addr=%h want ir=0 req=1 addr=11", IR_in_en, mem_req, mem_addr); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++; if (IR_in_en !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL stall_ir%0d: got ir=%b req=%b want ir=0 req=0", c, IR_in_en, mem_req); end
            checks++; if (instruction_out !== 16'hA011 || pc_out !== 8'h11 || mem_addr !== 8'h11) begin errors++; $display("FAIL stall_hold%0d: got instr=%h pc_out=%h pc=%h want A011/11/11", c, instruction_out, pc_out, mem_addr); end
        end
        stall = 1'b0;
        #1;
        checks++; if (IR_in_en !== 1'b1) begin errors++; $display("FAIL stall_release: got ir=%b want 1", IR_in_en); end
        tick();
        checks++; if (IR_in_en !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 8'h12) begin errors++; $display("FAIL stall_after: got ir=%b req=%b addr=%h want ir=0 req=1 addr=12", IR_in_en, mem_req, mem_addr); end
    endtask

    task automatic test_redirect();
        redirect_en = 1'b1; redirect_pc = 8'h40;
        #1;
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL redir_setup_ready: got %b want 1", mem_ready); end
        tick();
        redirect_en = 1'b0;
        checks++; if (mem_req !== 1'b0 || IR_in_en !== 1'b0 || mem_addr !== 8'h40) begin errors++; $display("FAIL redir_bubble: got req=%b ir=%b addr=%h want req=0 ir=0 addr=40", mem_req, IR_in_en, mem_addr); end
        checks++; if (instruction_out !== 16'hA011 || pc_out !== 8'h11) begin errors++; $display("FAIL redir_discard: got instr=%h pc_out=%h want A011/11", instruction_out, pc_out); end
        tick();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h40) begin errors++; $display("FAIL redir_fetch: got req=%b addr=%h want req=1 addr=40", mem_req, mem_addr); end
        tick();
        checks++; if (IR_in_en !== 1'b1 || pc_out !== 8'h40 || instruction_out !== 16'hA040) begin errors++; $display("FAIL redir_deliver: got ir=%b pc_out=%h instr=%h want 1/40/A040", IR_in_en, pc_out, instruction_out); end
        // Redirect over a pending delivery, with stall also high.
        redirect_en = 1'b1; redirect_pc = 8'hFF; stall = 1'b1;
        #1;
        checks++; if (IR_in_en !== 1'b0) begin errors++; $display("FAIL redir_blocks_ir: got %b want 0", IR_in_en); end
        tick();
        redirect_en = 1'b0; stall = 1'b0;
        checks++; if (mem_req !== 1'b0 || mem_addr !== 8'hFF || pc_out !== 8'h40) begin errors++; $display("FAIL redir_over_stall: got req=%b addr=%h pc_out=%h want 0/FF/40", mem_req, mem_addr, pc_out); end
    endtask

    task automatic test_wrap();
        tick();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 8'hFF) begin errors++; $display("FAIL wrap_fetch_ff: got req=%b addr=%h want 1/FF", mem_req, mem_addr); end
        tick();
        checks++; if (IR_in_en !== 1'b1 || instruction_out !== 16'hA0FF || pc_out !== 8'hFF) begin errors++; $display("FAIL wrap_deliver_ff: got ir=%b instr=%h pc_out=%h want 1/A0FF/FF", IR_in_en, instruction_out, pc_out); end
        tick();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin errors++; $display("FAIL wrap_to_zero: got req=%b addr=%h want 1/00", mem_req, mem_addr); end
        tick();
        checks++; if (instruction_out !== 16'hA000 || pc_out !== 8'h00) begin errors++; $display("FAIL wrap_deliver_00: got instr=%h pc_out=%h want A000/00", instruction_out, pc_out); end
    endtask

    task automatic test_reset_mid_fetch();
        tick();
        reset = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h01 || mem_ready !== 1'b1 || instruction_out !== 16'hA000) begin errors++; $display("FAIL reset_between_edges: got req=%b addr=%h rdy=%b instr=%h want 1/01/1/A000", mem_req, mem_addr, mem_ready, instruction_out); end
        tick();
        checks++; if (mem_req !== 1'b0 || IR_in_en !== 1'b0 || instruction_out !== 16'h0000) begin errors++; $display("FAIL reset_mid_clear: got req=%b ir=%b instr=%h want 0/0/0000", mem_req, IR_in_en, instruction_out); end
        checks++; if (mem_addr !== 8'h10 || pc_out !== 8'h10) begin errors++; $display("FAIL reset_mid_pc: got pc=%h pc_out=%h want 10/10", mem_addr, pc_out); end
        reset = 1'b0;
        tick();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h10) begin errors++; $display("FAIL reset_mid_restart: got req=%b addr=%h want 1/10", mem_req, mem_addr); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wait_states();
        test_stall();
        test_redirect();
        test_wrap();
        test_reset_mid_fetch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of the instruction register.
- Owns the program counter and issues word reads to instruction memory over a req/ready handshake.
- Presents each fetched 16-bit instruction together with a one-cycle IR load strobe.
- Honours a downstream stall and a branch/jump redirect from execute.

Parameters:
- PC_W, 8, program counter / instruction memory address width (word addressed).
- RESET_PC, 0, PC value loaded on reset (PC_W bits).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- run  input  1  fetch enable; low lets the in-flight instruction finish, then the block idles.
- stall  input  1  downstream cannot accept an instruction this cycle.
- redirect_en  input  1  one-cycle PC redirect (taken branch/jump).
- redirect_pc  input  PC_W  redirect target.
- mem_req  output  1  read request to instruction memory.
- mem_addr  output  PC_W  read address; equals pc.
- mem_ready  input  1  mem_rdata valid this cycle; meaningful only while mem_req=1.
- mem_rdata  input  16  instruction word from memory.
- instruction_out  output  16  registered fetched instruction; drives the IR data input.
- IR_in_en  output  1  IR load strobe; high for exactly one cycle per delivered instruction.
- pc_out  output  PC_W  address of the instruction currently held in instruction_out.

Behaviour:
- Registers:
  - pc
  - state in {IDLE, FETCH, DELIVER}
  - instruction_out
  - pc_out
- Reset (synchronous, next rising edge):
  - state=IDLE, pc=RESET_PC, instruction_out=16'h0000, pc_out=RESET_PC.
  - mem_req=0 and IR_in_en=0 in the cycle after the edge.
  - Reset dominates all other inputs.
  - Reset mid-fetch abandons the request; a mem_ready in the reset cycle is ignored.
- IDLE:
  - mem_req=0.
  - run=1 moves to FETCH; otherwise stay in IDLE.
- FETCH:
  - mem_req=1, mem_addr=pc. Address is held stable until mem_ready.
  - On mem_ready=1: instruction_out<=mem_rdata, pc_out<=pc, go to DELIVER.
  - Best-case latency: 1 cycle from FETCH entry to DELIVER (zero-wait memory).
- DELIVER:
  - mem_req=0.
  - IR_in_en = (state==DELIVER) & ~stall & ~redirect_en, decoded combinationally from the registered state.
  - When IR_in_en=1: pc<=pc+1, wrapping modulo 2^PC_W (all-ones -> 0). Next state is FETCH if run=1, else IDLE.
  - stall=1: remain in DELIVER; instruction_out, pc_out and pc are held; IR_in_en=0.
- Throughput: an instruction every 2 cycles with zero-wait memory and no stall.
- Redirect (redirect_en=1, any non-reset state):
  - pc<=redirect_pc; next state IDLE, so mem_req is low for one bubble cycle. The block then re-enters FETCH if run=1.
  - Takes priority over mem_ready in the same cycle: the returned data is discarded and instruction_out/pc_out are unchanged.
  - Takes priority over delivery in the same cycle: IR_in_en=0 and no increment.
  - Takes priority over stall.
- run falling:
  - In FETCH, the fetch completes and the instruction is delivered, then the block goes to IDLE.
  - In IDLE, the block stays idle.
  - No new mem_req is issued while run=0.
- IR_in_en is never high in two consecutive cycles.
- instruction_out only changes on a mem_ready capture or on reset.

Test Plan:
- Reset, RESET_PC=8'h10, run=1, zero-wait memory returning {8'hA0,addr} -> mem_addr sequence 10,11,12; instruction_out A010, A011, A012; IR_in_en pulses every 2nd cycle; pc_out matches each instruction's address.
- mem_ready delayed 3 cycles at addr 10 -> mem_req and mem_addr=10 held 4 cycles, single IR_in_en pulse, no duplicate or skipped address.
- stall=1 for 4 cycles while in DELIVER -> IR_in_en=0 throughout; instruction_out/pc_out/pc frozen; one pulse the cycle stall drops, then mem_addr increments.
- redirect_en with redirect_pc=8'h40 in the same cycle as mem_ready at addr 12 -> data discarded, IR_in_en=0, one mem_req=0 bubble, next mem_addr=40, next delivered pc_out=40.
- pc=8'hFF delivered -> next mem_addr=8'h00 (wrap).
- Synchronous reset asserted mid-FETCH with mem_ready=1 same cycle -> next cycle state IDLE, mem_req=0, instruction_out=0000, pc=RESET_PC; reset asserted between edges has no effect until the next edge.
